// File: rtl/dmem_arbiter_pkg.sv
// Shared types and default sizes for the data-memory arbiter between the
// core pipeline (CPU) and the network interface (NIC).
package dmem_arbiter_pkg;

  localparam int DATA_WIDTH_DEF   = 64;
  localparam int ADDR_WIDTH_DEF   = 16;
  localparam int LEN_WIDTH_DEF    = 4;
  localparam int STARVE_LIMIT_DEF = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_NIC = 1'b1
  } port_e;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick with a last-winner register; the winner is
// reported back by the caller so grants issued outside arbitration also count.
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  req_cpu_i,
  input  logic  req_nic_i,
  input  logic  win_cpu_i,
  input  logic  win_nic_i,
  output logic  pick_cpu_o,
  output logic  pick_nic_o,
  output port_e last_winner_o
);

  port_e last_q;

  always_comb begin
    pick_cpu_o = 1'b0;
    pick_nic_o = 1'b0;
    if (req_cpu_i && req_nic_i) begin
      pick_cpu_o = (last_q == PORT_NIC);
      pick_nic_o = (last_q == PORT_CPU);
    end else begin
      pick_cpu_o = req_cpu_i;
      pick_nic_o = req_nic_i;
    end
  end

  // Reset to NIC so that the CPU wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= PORT_NIC;
    end else if (win_cpu_i) begin
      last_q <= PORT_CPU;
    end else if (win_nic_i) begin
      last_q <= PORT_NIC;
    end
  end

  assign last_winner_o = last_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between CPU single accesses and NIC
// single/burst accesses; a NIC burst owns the memory except for starvation slots.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int LEN_WIDTH    = LEN_WIDTH_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_stall,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_rvalid,
  input  logic                  nic_req,
  input  logic                  nic_we,
  input  logic [ADDR_WIDTH-1:0] nic_addr,
  input  logic [DATA_WIDTH-1:0] nic_wdata,
  input  logic                  nic_burst,
  input  logic [LEN_WIDTH-1:0]  nic_len,
  output logic                  nic_gnt,
  output logic [DATA_WIDTH-1:0] nic_rdata,
  output logic                  nic_rvalid,
  output logic                  nic_burst_done,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output arb_state_e            dbg_state_o
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_e            state_q, state_d;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [ADDR_WIDTH-1:0] burst_addr_q, burst_addr_d;
  logic                  burst_we_q, burst_we_d;
  logic [SW-1:0]         starve_cnt_q, starve_cnt_d;
  logic                  cpu_rvalid_q, nic_rvalid_q;
  logic [LEN_WIDTH-1:0]  eff_len;
  logic                  pick_cpu, pick_nic;
  port_e                 last_winner;

  rr_arb2 u_rr_arb2 (
    .clk_i         (clk),
    .rst_ni        (rst),
    .req_cpu_i     (cpu_req),
    .req_nic_i     (nic_req),
    .win_cpu_i     (cpu_gnt),
    .win_nic_i     (nic_gnt),
    .pick_cpu_o    (pick_cpu),
    .pick_nic_o    (pick_nic),
    .last_winner_o (last_winner)
  );

  assign eff_len = (nic_len == '0) ? LEN_WIDTH'(1) : nic_len;

  // Handshake: a requester holds req and its address/data stable until gnt;
  // gnt is the cycle the access reaches memory, read data follows one cycle later.
  always_comb begin
    cpu_gnt        = 1'b0;
    nic_gnt        = 1'b0;
    nic_burst_done = 1'b0;
    state_d        = state_q;
    beat_cnt_d     = beat_cnt_q;
    burst_addr_d   = burst_addr_q;
    burst_we_d     = burst_we_q;
    if (rst) begin
      case (state_q)
        ST_IDLE: begin
          cpu_gnt = pick_cpu;
          nic_gnt = pick_nic;
          if (pick_nic) begin
            if (nic_burst && (eff_len > LEN_WIDTH'(1))) begin
              burst_addr_d = nic_addr + ADDR_WIDTH'(1);
              burst_we_d   = nic_we;
              beat_cnt_d   = eff_len - LEN_WIDTH'(1);
              state_d      = ST_BURST;
            end else begin
              nic_burst_done = nic_burst;
            end
          end
        end
        ST_BURST: begin
          if (!nic_req) begin
            state_d    = ST_IDLE;
            beat_cnt_d = '0;
          end else if (cpu_req && (starve_cnt_q == SW'(STARVE_LIMIT))) begin
            cpu_gnt = 1'b1;
          end else begin
            nic_gnt      = 1'b1;
            burst_addr_d = burst_addr_q + ADDR_WIDTH'(1);
            beat_cnt_d   = beat_cnt_q - LEN_WIDTH'(1);
            if (beat_cnt_q == LEN_WIDTH'(1)) begin
              nic_burst_done = 1'b1;
              state_d        = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (cpu_gnt) begin
      mem_en   = 1'b1;
      mem_we   = cpu_we;
      mem_addr = cpu_addr;
      mem_din  = cpu_wdata;
    end else if (nic_gnt) begin
      mem_en   = 1'b1;
      mem_we   = (state_q == ST_BURST) ? burst_we_q : nic_we;
      mem_addr = (state_q == ST_BURST) ? burst_addr_q : nic_addr;
      mem_din  = nic_wdata;
    end
  end

  // Saturating so a long wait cannot wrap past the limit.
  always_comb begin
    starve_cnt_d = '0;
    if (cpu_req && !cpu_gnt) begin
      starve_cnt_d = (starve_cnt_q == SW'(STARVE_LIMIT)) ? starve_cnt_q
                                                         : starve_cnt_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      beat_cnt_q   <= '0;
      burst_addr_q <= '0;
      burst_we_q   <= 1'b0;
      starve_cnt_q <= '0;
      cpu_rvalid_q <= 1'b0;
      nic_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      burst_addr_q <= burst_addr_d;
      burst_we_q   <= burst_we_d;
      starve_cnt_q <= starve_cnt_d;
      cpu_rvalid_q <= cpu_gnt & ~cpu_we;
      nic_rvalid_q <= nic_gnt & ~mem_we;
    end
  end

  assign cpu_stall   = cpu_req & ~cpu_gnt;
  assign cpu_rdata   = mem_dout;
  assign nic_rdata   = mem_dout;
  assign cpu_rvalid  = cpu_rvalid_q;
  assign nic_rvalid  = nic_rvalid_q;
  assign dbg_state_o = state_q;

  logic unused_last;
  assign unused_last = (last_winner == PORT_CPU);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, CPU read, round-robin ties, burst
// address wrap, starvation slot, burst abort and asynchronous reset mid-burst.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int DW = 64;
  localparam int AW = 16;
  localparam int LW = 4;

  logic          clk;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt, cpu_stall, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          nic_req, nic_we, nic_burst;
  logic [AW-1:0] nic_addr;
  logic [DW-1:0] nic_wdata;
  logic [LW-1:0] nic_len;
  logic          nic_gnt, nic_rvalid, nic_burst_done;
  logic [DW-1:0] nic_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;
  arb_state_e    dbg_state;

  int total = 0;
  int bad   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .nic_req(nic_req), .nic_we(nic_we), .nic_addr(nic_addr), .nic_wdata(nic_wdata),
    .nic_burst(nic_burst), .nic_len(nic_len), .nic_gnt(nic_gnt), .nic_rdata(nic_rdata),
    .nic_rvalid(nic_rvalid), .nic_burst_done(nic_burst_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .dbg_state_o(dbg_state)
  );

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    nic_req = 0; nic_we = 0; nic_addr = '0; nic_wdata = '0;
    nic_burst = 0; nic_len = '0; mem_dout = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #2 rst = 1'b0;
    cpu_req = 1; nic_req = 1; cpu_addr = 16'h1234; nic_addr = 16'h5678;
    #1;
    total++;
    if ({cpu_gnt, nic_gnt, mem_en, mem_we, nic_burst_done} !== 5'b0) begin
      bad++; $display("FAIL reset_grants got=%b exp=00000", {cpu_gnt, nic_gnt, mem_en, mem_we, nic_burst_done});
    end
    total++;
    if ({mem_addr, mem_din} !== '0) begin
      bad++; $display("FAIL reset_mem_bus got addr=%h din=%h exp=0", mem_addr, mem_din);
    end
    total++;
    if ({cpu_rvalid, nic_rvalid} !== 2'b00 || dbg_state !== ST_IDLE) begin
      bad++; $display("FAIL reset_rvalid_state got rv=%b st=%0d exp rv=00 st=0", {cpu_rvalid, nic_rvalid}, dbg_state);
    end
    do_reset();
  endtask

  task automatic test_cpu_read();
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    @(negedge clk);
    total++;
    if ({cpu_gnt, mem_en, mem_we, cpu_stall} !== 4'b1100 || mem_addr !== 16'h0010) begin
      bad++; $display("FAIL cpu_read_issue got gnt/en/we/stall=%b addr=%h exp 1100 0010", {cpu_gnt, mem_en, mem_we, cpu_stall}, mem_addr);
    end
    next_cycle();
    cpu_req = 0;
    mem_dout = 64'hDEAD_BEEF_0123_4567;
    @(negedge clk);
    total++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 64'hDEAD_BEEF_0123_4567 || nic_rvalid !== 1'b0) begin
      bad++; $display("FAIL cpu_read_data got rv=%b data=%h nrv=%b exp 1 deadbeef01234567 0", cpu_rvalid, cpu_rdata, nic_rvalid);
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic          exp_cpu;
    logic          exp_nrv;
    logic [AW-1:0] exp_addr;
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0020; cpu_wdata = 64'hAA;
    nic_req = 1; nic_we = 0; nic_addr = 16'h0030; nic_burst = 0;
    for (int i = 0; i < 4; i++) begin
      exp_cpu  = (i % 2 == 0);
      exp_nrv  = (i % 2 == 0) && (i > 0);
      exp_addr = exp_cpu ? 16'h0020 : 16'h0030;
      @(negedge clk);
      total++;
      if (cpu_gnt !== exp_cpu || nic_gnt !== ~exp_cpu || cpu_stall !== ~exp_cpu) begin
        bad++; $display("FAIL rr_grant[%0d] got cpu=%b nic=%b stall=%b exp cpu=%b", i, cpu_gnt, nic_gnt, cpu_stall, exp_cpu);
      end
      total++;
      if (mem_addr !== exp_addr || nic_rvalid !== exp_nrv || cpu_rvalid !== 1'b0 || nic_burst_done !== 1'b0) begin
        bad++; $display("FAIL rr_bus[%0d] got addr=%h nrv=%b crv=%b done=%b exp addr=%h nrv=%b", i, mem_addr, nic_rvalid, cpu_rvalid, nic_burst_done, exp_addr, exp_nrv);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_burst_wrap();
    logic [AW-1:0] exp_addr [4];
    exp_addr[0] = 16'hFFFE; exp_addr[1] = 16'hFFFF; exp_addr[2] = 16'h0000; exp_addr[3] = 16'h0001;
    do_reset();
    nic_req = 1; nic_burst = 1; nic_len = 4'd4; nic_we = 1; nic_addr = 16'hFFFE;
    for (int i = 0; i < 4; i++) begin
      nic_wdata = 64'h100 + 64'(i);
      @(negedge clk);
      total++;
      if (nic_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== exp_addr[i] || mem_din !== 64'h100 + 64'(i)) begin
        bad++; $display("FAIL burst_beat[%0d] got gnt=%b we=%b addr=%h din=%h exp 1 1 %h %h", i, nic_gnt, mem_we, mem_addr, mem_din, exp_addr[i], 64'h100 + 64'(i));
      end
      total++;
      if (nic_burst_done !== (i == 3)) begin
        bad++; $display("FAIL burst_done[%0d] got=%b exp=%b", i, nic_burst_done, (i == 3));
      end
      next_cycle();
      nic_addr = 16'h1234;
    end
    nic_req = 0;
    @(negedge clk);
    total++;
    if (dbg_state !== ST_IDLE || nic_gnt !== 1'b0 || mem_en !== 1'b0) begin
      bad++; $display("FAIL burst_end got st=%0d gnt=%b en=%b exp 0 0 0", dbg_state, nic_gnt, mem_en);
    end
    next_cycle();
  endtask

  task automatic test_starvation();
    logic          exp_cpu, prev_cpu, prev_nic, exp_done;
    logic [AW-1:0] exp_addr;
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040;
    @(negedge clk);
    total++;
    if (cpu_gnt !== 1'b1) begin
      bad++; $display("FAIL starve_prelude got=%b exp=1", cpu_gnt);
    end
    next_cycle();
    cpu_addr = 16'h0041;
    nic_req = 1; nic_burst = 1; nic_len = 4'd15; nic_we = 0; nic_addr = 16'h0200;
    prev_cpu = 1; prev_nic = 0;
    for (int c = 0; c < 16; c++) begin
      exp_cpu  = (c == 8);
      exp_done = (c == 15);
      exp_addr = exp_cpu ? 16'h0041 : (c < 8 ? 16'h0200 + 16'(c) : 16'h0200 + 16'(c - 1));
      @(negedge clk);
      total++;
      if (cpu_gnt !== exp_cpu || nic_gnt !== ~exp_cpu || mem_addr !== exp_addr || nic_burst_done !== exp_done) begin
        bad++; $display("FAIL starve_cyc[%0d] got cpu=%b nic=%b addr=%h done=%b exp cpu=%b addr=%h done=%b", c, cpu_gnt, nic_gnt, mem_addr, nic_burst_done, exp_cpu, exp_addr, exp_done);
      end
      total++;
      if (cpu_rvalid !== prev_cpu || nic_rvalid !== prev_nic) begin
        bad++; $display("FAIL starve_rv[%0d] got crv=%b nrv=%b exp crv=%b nrv=%b", c, cpu_rvalid, nic_rvalid, prev_cpu, prev_nic);
      end
      prev_cpu = exp_cpu;
      prev_nic = ~exp_cpu;
      next_cycle();
    end
    nic_req = 0;
    @(negedge clk);
    total++;
    if (dbg_state !== ST_IDLE || cpu_gnt !== 1'b1) begin
      bad++; $display("FAIL starve_after got st=%0d cpu=%b exp 0 1", dbg_state, cpu_gnt);
    end
    next_cycle();
  endtask

  task automatic test_abort();
    do_reset();
    nic_req = 1; nic_burst = 1; nic_len = 4'd6; nic_we = 1; nic_addr = 16'h0300;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (nic_gnt !== 1'b1 || mem_addr !== 16'h0300 + 16'(c)) begin
        bad++; $display("FAIL abort_beat[%0d] got gnt=%b addr=%h exp 1 %h", c, nic_gnt, mem_addr, 16'h0300 + 16'(c));
      end
      next_cycle();
    end
    nic_req = 0;
    @(negedge clk);
    total++;
    if (nic_gnt !== 1'b0 || mem_en !== 1'b0 || nic_burst_done !== 1'b0 || dbg_state !== ST_BURST) begin
      bad++; $display("FAIL abort_drop got gnt=%b en=%b done=%b st=%0d exp 0 0 0 1", nic_gnt, mem_en, nic_burst_done, dbg_state);
    end
    next_cycle();
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0050;
    @(negedge clk);
    total++;
    if (cpu_gnt !== 1'b1 || mem_addr !== 16'h0050 || dbg_state !== ST_IDLE) begin
      bad++; $display("FAIL abort_cpu got gnt=%b addr=%h st=%0d exp 1 0050 0", cpu_gnt, mem_addr, dbg_state);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    nic_req = 1; nic_burst = 1; nic_len = 4'd8; nic_we = 0; nic_addr = 16'h0400;
    repeat (2) next_cycle();
    total++;
    if (nic_gnt !== 1'b1 || nic_rvalid !== 1'b1 || mem_addr !== 16'h0402) begin
      bad++; $display("FAIL areset_pre got gnt=%b rv=%b addr=%h exp 1 1 0402", nic_gnt, nic_rvalid, mem_addr);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if (nic_gnt !== 1'b0 || mem_en !== 1'b0 || nic_rvalid !== 1'b0 || mem_addr !== '0 || dbg_state !== ST_IDLE) begin
      bad++; $display("FAIL areset_now got gnt=%b en=%b rv=%b addr=%h st=%0d exp all 0", nic_gnt, mem_en, nic_rvalid, mem_addr, dbg_state);
    end
    idle_inputs();
    next_cycle();
    rst = 1'b1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0060;
    @(negedge clk);
    total++;
    if (cpu_gnt !== 1'b1 || mem_addr !== 16'h0060) begin
      bad++; $display("FAIL areset_after got gnt=%b addr=%h exp 1 0060", cpu_gnt, mem_addr);
    end
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_cpu_read();
    test_round_robin();
    test_burst_wrap();
    test_starvation();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single synchronous data memory between two requesters: the core pipeline (CPU port) and the network interface (NIC port).
- CPU single-word accesses and NIC single or burst accesses are arbitrated round-robin. A NIC burst locks the memory, with a starvation escape for the CPU.
- Sits between the pipeline's stage-3 memory interface and the dmem instance. cpu_stall feeds the pipeline freeze logic.

Parameters:
- DATA_WIDTH, 64, memory word width.
- ADDR_WIDTH, 16, dmem word-address width.
- LEN_WIDTH, 4, burst length field width; maximum burst is 2^LEN_WIDTH-1 (15).
- STARVE_LIMIT, 8, consecutive CPU wait cycles during a NIC burst before one CPU slot is forced.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cpu_req  in  1  CPU access request, held until granted.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  ADDR_WIDTH  CPU word address.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_gnt  out  1  CPU access issued to memory this cycle.
- cpu_stall  out  1  cpu_req & ~cpu_gnt.
- cpu_rdata  out  DATA_WIDTH  read data; equals mem_dout.
- cpu_rvalid  out  1  cpu_rdata valid this cycle.
- nic_req  in  1  NIC request, held for the whole burst.
- nic_we  in  1  1=write, 0=read; sampled at burst start.
- nic_addr  in  ADDR_WIDTH  base address; sampled at grant of the first beat.
- nic_wdata  in  DATA_WIDTH  write data for the current beat.
- nic_burst  in  1  1=burst of nic_len beats, 0=single beat.
- nic_len  in  LEN_WIDTH  burst length; 0 is treated as 1.
- nic_gnt  out  1  NIC beat issued this cycle; NIC advances nic_wdata on it.
- nic_rdata  out  DATA_WIDTH  read data; equals mem_dout.
- nic_rvalid  out  1  nic_rdata valid this cycle.
- nic_burst_done  out  1  one-cycle pulse in the cycle the last beat is granted.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_din  out  DATA_WIDTH  memory write data.
- mem_dout  in  DATA_WIDTH  memory read data, valid one cycle after a read enable.

Behaviour:

Reset (rst=0, async):
- State goes to IDLE; last_winner=NIC, so the CPU wins the first tie.
- beat_cnt=0, burst_addr=0, starve_cnt=0.
- cpu_rvalid=0, nic_rvalid=0.
- All grants, mem_en, mem_we and nic_burst_done are 0.
- mem_addr and mem_din are 0 while mem_en=0.

Grants and data path:
- Grants are combinational from the current state and requests. At most one grant per cycle.
- mem_* is driven from the granted port in the same cycle.
- Read latency is 1: x_rvalid is registered and equals (x_gnt & ~x_we) delayed one cycle. rdata passes mem_dout through.

States:
- IDLE:
  - Only cpu_req: grant CPU.
  - Only nic_req: grant NIC.
  - Both: grant the port that is not last_winner; last_winner updates on every grant.
  - NIC granted with nic_burst=1 and effective length L>1: latch nic_addr+1 into burst_addr, nic_we into burst_we, beat_cnt=L-1; go to BURST.
  - NIC granted with nic_burst=1 and L=1, or with nic_burst=0: pulse nic_burst_done only if nic_burst=1; stay in IDLE.
- BURST:
  - Default: grant NIC with mem_addr=burst_addr and mem_we=burst_we.
  - Each grant increments burst_addr (wraps 2^ADDR_WIDTH-1 to 0) and decrements beat_cnt.
  - When beat_cnt==1 at grant: pulse nic_burst_done, set last_winner=NIC, go to IDLE.
  - starve_cnt increments each cycle cpu_req=1 without a grant; it clears on any CPU grant or when cpu_req=0.
  - When starve_cnt==STARVE_LIMIT: this cycle grants the CPU instead (burst paused, beat_cnt and burst_addr held), starve_cnt clears, state stays BURST.
  - nic_req=0 in BURST: abort. No grant that cycle, go to IDLE, beat_cnt=0, no done pulse.
- Reset mid-burst: the burst is abandoned and outstanding rvalid is dropped.
- CPU request held through a stall: the CPU must keep addr, we and wdata stable until cpu_gnt.

Decomposition:
- Shared package: state encoding (IDLE, BURST), port IDs (PORT_CPU, PORT_NIC), default widths.
- Natural sub-module: rr_arb2, a 2-request round-robin arbiter with a last-winner register.
- Burst counter, address counter and starvation counter live in dmem_arbiter.

Test Plan:
1. CPU-only read, addr 0x0010: cpu_gnt same cycle, mem_en=1, mem_we=0. Next cycle cpu_rvalid=1 and cpu_rdata=mem_dout.
2. Simultaneous single requests, held 4 cycles: grants alternate CPU, NIC, CPU, NIC; cpu_stall=1 on the NIC cycles.
3. NIC write burst, len 4, base 0xFFFE: mem_addr runs 0xFFFE, 0xFFFF, 0x0000, 0x0001 on consecutive cycles. nic_burst_done pulses with the 4th grant, then IDLE.
4. NIC read burst, len 15, with cpu_req high throughout and STARVE_LIMIT=8: after 8 NIC beats the CPU gets one slot, then the NIC resumes at the next address. Total 16 cycles, no beat lost.
5. nic_req dropped after 2 of 6 beats: no grant in the drop cycle, no nic_burst_done, a CPU request in the following cycle is granted.
6. rst asserted mid-burst, asynchronously: outputs go to 0 immediately. After release a new CPU request is granted in IDLE.
